pipelined_rca_adder: RTL

Parametrised, pipelined successor to the gate-level 8-bit ripple-carry adder. It splits a WIDTH-bit add/subtract into CHUNK-bit ripple slices, with one slice per pipeline stage and the carry registered between stages. A valid/ready handshake on both sides lets it sit in streaming datapaths, giving one result per cycle at full throughput. Subtract mode and flag outputs are new relative to the 8-bit adder.

---
 rtl/pipelined_rca_adder_pkg.sv | 28 ++
 rtl/pipelined_rca_adder_rca_chunk.sv | 47 ++++
 rtl/pipelined_rca_adder.sv | 114 +++++++++++
 3 files changed

// File: rtl/pipelined_rca_adder_pkg.sv
// Shared helpers for the pipelined ripple-carry adder: stage count and slice bounds.
package pipelined_rca_adder_pkg;

  // Pipeline depth: one ripple slice per stage.
  function automatic int unsigned num_stages(input int unsigned width,
                                             input int unsigned chunk);
    return width / chunk;
  endfunction

  // Lowest bit index of slice k.
  function automatic int unsigned slice_lo(input int unsigned k,
                                           input int unsigned chunk);
    return k * chunk;
  endfunction

  // Highest bit index of slice k.
  function automatic int unsigned slice_hi(input int unsigned k,
                                           input int unsigned chunk);
    return (k * chunk) + chunk - 1;
  endfunction

  // Legal configuration: non-empty slice that tiles the word exactly.
  function automatic bit chunk_fits(input int unsigned width,
                                    input int unsigned chunk);
    return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/pipelined_rca_adder_rca_chunk.sv
// Combinational CHUNK-bit ripple slice built from full_adder cells.

// Single-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// Ripple slice; c_top is the carry into the slice's top bit (feeds overflow).
module rca_chunk #(
  parameter int unsigned CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_top
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = cin;

  // Carry chain through the cells.
  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (w_c[i]),
      .s    (s[i]),
      .cout (w_c[i+1])
    );
  end

  assign cout  = w_c[CHUNK];
  assign c_top = w_c[CHUNK-1];

endmodule

// File: rtl/pipelined_rca_adder.sv
// Pipelined add/subtract: one CHUNK-bit ripple slice per stage, registered carry
// between stages, skewed operands and deskewed results, valid/ready on both ends.
module pipelined_rca_adder
  import pipelined_rca_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NS = num_stages(WIDTH, CHUNK);

  if (!chunk_fits(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("pipelined_rca_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  // Per-stage registers: index k is the output of stage k.
  logic [NS-1:0]    r_v;
  logic [NS-1:0]    r_c;
  logic [WIDTH-1:0] r_a [NS];
  logic [WIDTH-1:0] r_b [NS];
  logic [WIDTH-1:0] r_s [NS];
  logic             r_ovf;

  // Per-stage inputs and slice results.
  logic [NS-1:0]    w_v_in;
  logic [NS-1:0]    w_c_in;
  logic [NS-1:0]    w_co;
  logic             w_ctop [NS];
  logic [WIDTH-1:0] w_a_in [NS];
  logic [WIDTH-1:0] w_b_in [NS];
  logic [WIDTH-1:0] w_s_in [NS];
  logic [WIDTH-1:0] w_s_nx [NS];
  logic [CHUNK-1:0] w_cs   [NS];
  logic             w_adv;

  // Whole pipeline moves only when the output slot is free or being drained.
  assign w_adv    = !r_v[NS-1] || out_ready;
  assign in_ready = w_adv;

  for (genvar k = 0; k < NS; k++) begin : g_stage
    localparam int unsigned LO = slice_lo(k, CHUNK);
    localparam int unsigned HI = slice_hi(k, CHUNK);

    if (k == 0) begin : g_first
      // Operand conditioning: subtract is A + ~B + 1.
      assign w_v_in[k] = in_valid;
      assign w_a_in[k] = a;
      assign w_b_in[k] = sub ? ~b : b;
      assign w_c_in[k] = sub | cin;
      assign w_s_in[k] = '0;
    end else begin : g_next
      assign w_v_in[k] = r_v[k-1];
      assign w_a_in[k] = r_a[k-1];
      assign w_b_in[k] = r_b[k-1];
      assign w_c_in[k] = r_c[k-1];
      assign w_s_in[k] = r_s[k-1];
    end

    rca_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a     (w_a_in[k][HI:LO]),
      .b     (w_b_in[k][HI:LO]),
      .cin   (w_c_in[k]),
      .s     (w_cs[k]),
      .cout  (w_co[k]),
      .c_top (w_ctop[k])
    );

    // Result bits above the finished slices are still zero, so OR merges the new slice.
    assign w_s_nx[k] = w_s_in[k] | (WIDTH'(w_cs[k]) << LO);
  end

  // Stage registers with global stall and synchronous flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v   <= '0;
      r_c   <= '0;
      r_ovf <= 1'b0;
      for (int k = 0; k < int'(NS); k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
      end
    end else if (w_adv) begin
      r_v   <= w_v_in;
      r_c   <= w_co;
      r_ovf <= w_ctop[NS-1] ^ w_co[NS-1];
      for (int k = 0; k < int'(NS); k++) begin
        r_a[k] <= w_a_in[k];
        r_b[k] <= w_b_in[k];
        r_s[k] <= w_s_nx[k];
      end
    end
  end

  assign out_valid = r_v[NS-1];
  assign sum       = r_s[NS-1];
  assign cout      = r_c[NS-1];
  assign ovf       = r_ovf;

endmodule
